// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the unified-memory port arbiter.
//   arb_state_t  : arbiter FSM states (IDLE -> BUSY -> RESP -> IDLE)
//   arb_owner_t  : which requester owns the current memory transaction
//   FUNCT3_LW    : access size used for every instruction fetch (word)
//   WAIT_CNT_W   : width of the IF starvation counter (holds 0..15)
//   wait_cnt_inc : saturating increment for the starvation counter
// -----------------------------------------------------------------------------
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'b00,
      ARB_BUSY = 2'b01,
      ARB_RESP = 2'b10
   } arb_state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_DM = 1'b1
   } arb_owner_t;

   localparam logic [2:0] FUNCT3_LW  = 3'b010;
   localparam int         WAIT_CNT_W = 4;

   // Saturating increment: the counter never wraps past the starvation limit.
   function automatic logic [WAIT_CNT_W-1:0] wait_cnt_inc(
      input logic [WAIT_CNT_W-1:0] cnt,
      input logic [WAIT_CNT_W-1:0] limit
   );
      logic [WAIT_CNT_W-1:0] res;
      if (cnt >= limit) begin
         res = limit;
      end else begin
         res = cnt + {{(WAIT_CNT_W-1){1'b0}}, 1'b1};
      end
      return res;
   endfunction

endpackage

// File: rtl/arb_prio_select.sv
// -----------------------------------------------------------------------------
// arb_prio_select
// Combinational owner pick for the memory arbiter. DM wins a tie unless IF has
// been passed over too often, in which case IF wins.
// Ports:
//   if_req      in   IF requests the memory
//   dm_req      in   DM requests the memory
//   if_starved  in   IF has lost the maximum number of ties in a row
//   grant_valid out  at least one requester is present
//   grant_owner out  requester that would be granted (OWN_IF when idle)
// -----------------------------------------------------------------------------
module arb_prio_select
   import mem_arb_pkg::*;
(
   input  logic       if_req,
   input  logic       dm_req,
   input  logic       if_starved,
   output logic       grant_valid,
   output arb_owner_t grant_owner
);

   // Priority decode of the two request lines.
   always_comb begin
      grant_valid = 1'b0;
      grant_owner = OWN_IF;
      case ({if_req, dm_req})
         2'b10: begin
            grant_valid = 1'b1;
            grant_owner = OWN_IF;
         end
         2'b01: begin
            grant_valid = 1'b1;
            grant_owner = OWN_DM;
         end
         2'b11: begin
            grant_valid = 1'b1;
            if (if_starved) begin
               grant_owner = OWN_IF;
            end else begin
               grant_owner = OWN_DM;
            end
         end
         default: begin
            grant_valid = 1'b0;
            grant_owner = OWN_IF;
         end
      endcase
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-ported unified memory between the instruction-fetch port
// (IF) and the data-memory port (DM). One transaction at a time; DM has
// priority, a saturating counter guarantees IF forward progress.
// Ports:
//   clk, reset                 clock (rising edge), async active-low reset
//   if_req/if_addr             IF read request (held until if_done)
//   if_rdata/if_done/if_stall  IF read data, completion pulse, stall
//   dm_req/dm_we/dm_addr       DM request (held until dm_done), store flag, address
//   dm_wdata/dm_func3          DM store data and access size
//   dm_rdata/dm_done/dm_stall  DM load data, completion pulse, stall
//   mem_req/mem_we/mem_addr    memory transaction valid, write enable, address
//   mem_wdata/mem_func3        memory write data and access size
//   mem_ready/mem_rdata        memory completion and read data
// -----------------------------------------------------------------------------
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W   = 9,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_done,
   output logic              if_stall,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   input  logic [2:0]        dm_func3,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_done,
   output logic              dm_stall,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [2:0]        mem_func3,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [WAIT_CNT_W-1:0] MAX_WAIT_C = WAIT_CNT_W'(MAX_WAIT);

   arb_state_t              state_r;
   arb_state_t              state_nxt_s;
   arb_owner_t              owner_r;
   arb_owner_t              grant_owner_s;
   logic                    grant_valid_s;
   logic                    if_starved_s;
   logic                    grant_s;
   logic                    complete_s;
   logic [WAIT_CNT_W-1:0]   wait_cnt_r;
   logic                    run_r;
   logic                    mem_req_r;
   logic                    mem_we_r;
   logic [ADDR_W-1:0]       lat_addr_r;
   logic [DATA_W-1:0]       lat_wdata_r;
   logic [2:0]              lat_func3_r;
   logic                    sel_we_s;
   logic [ADDR_W-1:0]       sel_addr_s;
   logic [DATA_W-1:0]       sel_wdata_s;
   logic [2:0]              sel_func3_s;
   logic [DATA_W-1:0]       if_rdata_r;
   logic [DATA_W-1:0]       dm_rdata_r;
   logic                    if_done_r;
   logic                    dm_done_r;

   assign if_starved_s = (wait_cnt_r == MAX_WAIT_C);

   arb_prio_select u_prio (
      .if_req      (if_req),
      .dm_req      (dm_req),
      .if_starved  (if_starved_s),
      .grant_valid (grant_valid_s),
      .grant_owner (grant_owner_s)
   );

   // Requests are only looked at in IDLE; mem_ready only counts in BUSY.
   assign grant_s    = (state_r == ARB_IDLE) & grant_valid_s;
   assign complete_s = (state_r == ARB_BUSY) & mem_ready;

   // Next-state logic. RESP always returns to IDLE so a requester still
   // holding req during its done cycle is not granted a second time.
   always_comb begin
      state_nxt_s = ARB_IDLE;
      case (state_r)
         ARB_IDLE: begin
            if (grant_s) begin
               state_nxt_s = ARB_BUSY;
            end else begin
               state_nxt_s = ARB_IDLE;
            end
         end
         ARB_BUSY: begin
            if (mem_ready) begin
               state_nxt_s = ARB_RESP;
            end else begin
               state_nxt_s = ARB_BUSY;
            end
         end
         ARB_RESP: begin
            state_nxt_s = ARB_IDLE;
         end
         default: begin
            state_nxt_s = ARB_IDLE;
         end
      endcase
   end

   // Transaction fields of the winning port; fetches are always word reads.
   always_comb begin
      sel_we_s    = 1'b0;
      sel_addr_s  = if_addr;
      sel_wdata_s = {DATA_W{1'b0}};
      sel_func3_s = FUNCT3_LW;
      if (grant_owner_s == OWN_DM) begin
         sel_we_s    = dm_we;
         sel_addr_s  = dm_addr;
         sel_wdata_s = dm_wdata;
         sel_func3_s = dm_func3;
      end else begin
         sel_we_s    = 1'b0;
         sel_addr_s  = if_addr;
         sel_wdata_s = {DATA_W{1'b0}};
         sel_func3_s = FUNCT3_LW;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= ARB_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Registered memory request, high exactly while the FSM is in BUSY.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_req_r <= 1'b0;
      end else begin
         mem_req_r <= (state_nxt_s == ARB_BUSY);
      end
   end

   // Run flag: keeps the stall outputs low while reset is held and until the
   // first clock edge after release.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         run_r <= 1'b0;
      end else begin
         run_r <= 1'b1;
      end
   end

   // Transaction latches: captured on grant, so requester changes in BUSY
   // never reach the memory. Write enable drops when the transaction ends.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         owner_r     <= OWN_IF;
         mem_we_r    <= 1'b0;
         lat_addr_r  <= {ADDR_W{1'b0}};
         lat_wdata_r <= {DATA_W{1'b0}};
         lat_func3_r <= 3'b000;
      end else if (grant_s) begin
         owner_r     <= grant_owner_s;
         mem_we_r    <= sel_we_s;
         lat_addr_r  <= sel_addr_s;
         lat_wdata_r <= sel_wdata_s;
         lat_func3_r <= sel_func3_s;
      end else if (complete_s) begin
         mem_we_r    <= 1'b0;
      end
   end

   // IF starvation counter: counts DM wins while IF waits, clears on IF grant.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wait_cnt_r <= {WAIT_CNT_W{1'b0}};
      end else if (grant_s) begin
         if (grant_owner_s == OWN_IF) begin
            wait_cnt_r <= {WAIT_CNT_W{1'b0}};
         end else if (if_req) begin
            wait_cnt_r <= wait_cnt_inc(wait_cnt_r, MAX_WAIT_C);
         end
      end
   end

   // Completion pulses: set for the single RESP cycle after mem_ready.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         if_done_r <= 1'b0;
         dm_done_r <= 1'b0;
      end else begin
         if_done_r <= complete_s & (owner_r == OWN_IF);
         dm_done_r <= complete_s & (owner_r == OWN_DM);
      end
   end

   // Read-data registers: updated only by a completed load of that port.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         if_rdata_r <= {DATA_W{1'b0}};
         dm_rdata_r <= {DATA_W{1'b0}};
      end else if (complete_s && !mem_we_r) begin
         if (owner_r == OWN_IF) begin
            if_rdata_r <= mem_rdata;
         end else begin
            dm_rdata_r <= mem_rdata;
         end
      end
   end

   assign mem_req   = mem_req_r;
   assign mem_we    = mem_we_r;
   assign mem_addr  = lat_addr_r;
   assign mem_wdata = lat_wdata_r;
   assign mem_func3 = lat_func3_r;

   assign if_rdata  = if_rdata_r;
   assign if_done   = if_done_r;
   assign dm_rdata  = dm_rdata_r;
   assign dm_done   = dm_done_r;

   // Stalls follow the live request so the hazard unit sees them in cycle 0.
   assign if_stall  = run_r & if_req & ~if_done_r;
   assign dm_stall  = run_r & dm_req & ~dm_done_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

   logic        clk;
   logic        reset;
   logic        if_req;
   logic [8:0]  if_addr;
   logic [31:0] if_rdata;
   logic        if_done;
   logic        if_stall;
   logic        dm_req;
   logic        dm_we;
   logic [8:0]  dm_addr;
   logic [31:0] dm_wdata;
   logic [2:0]  dm_func3;
   logic [31:0] dm_rdata;
   logic        dm_done;
   logic        dm_stall;
   logic        mem_req;
   logic        mem_we;
   logic [8:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [2:0]  mem_func3;
   logic        mem_ready;
   logic [31:0] mem_rdata;

   int n_checks = 0;
   int n_fail   = 0;

   mem_port_arbiter #(.ADDR_W(9), .DATA_W(32), .MAX_WAIT(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_rdata  (if_rdata),
      .if_done   (if_done),
      .if_stall  (if_stall),
      .dm_req    (dm_req),
      .dm_we     (dm_we),
      .dm_addr   (dm_addr),
      .dm_wdata  (dm_wdata),
      .dm_func3  (dm_func3),
      .dm_rdata  (dm_rdata),
      .dm_done   (dm_done),
      .dm_stall  (dm_stall),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_func3 (mem_func3),
      .mem_ready (mem_ready),
      .mem_rdata (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        if_req;
      logic [8:0]  if_addr;
      logic        dm_req;
      logic        dm_we;
      logic [8:0]  dm_addr;
      logic [31:0] dm_wdata;
      logic [2:0]  dm_func3;
      logic        mem_ready;
      logic [31:0] mem_rdata;
      logic        e_mem_req;
      logic        e_mem_we;
      logic [8:0]  e_mem_addr;
      logic [31:0] e_mem_wdata;
      logic [2:0]  e_mem_func3;
      logic        e_if_done;
      logic [31:0] e_if_rdata;
      logic        e_if_stall;
      logic        e_dm_done;
      logic [31:0] e_dm_rdata;
      logic        e_dm_stall;
   } vec_t;

   localparam int NVEC = 17;
   vec_t vecs [NVEC];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      if_req    = 1'b0;
      if_addr   = 9'h000;
      dm_req    = 1'b0;
      dm_we     = 1'b0;
      dm_addr   = 9'h000;
      dm_wdata  = 32'h0;
      dm_func3  = 3'b000;
      mem_ready = 1'b0;
      mem_rdata = 32'h0;
   endtask

   initial begin
      int exp_order [10];
      int order_q [$];
      int lat;

      // inputs (if..mem_rdata) | expected (mem_req we addr wdata func3 | if_done if_rdata if_stall | dm_done dm_rdata dm_stall)
      // IF fetch, 0-wait memory; req dropped the cycle after done
      vecs[0]  = '{1'b1, 9'h010, 1'b0, 1'b0, 9'h000, 32'h0, 3'b000, 1'b0, 32'h0,        1'b0, 1'b0, 9'h000, 32'h0, 3'b000, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0};
      vecs[1]  = '{1'b1, 9'h010, 1'b0, 1'b0, 9'h000, 32'h0, 3'b000, 1'b1, 32'h00500093, 1'b1, 1'b0, 9'h010, 32'h0, 3'b010, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0};
      vecs[2]  = '{1'b1, 9'h010, 1'b0, 1'b0, 9'h000, 32'h0, 3'b000, 1'b0, 32'h0,        1'b0, 1'b0, 9'h000, 32'h0, 3'b000, 1'b1, 32'h00500093, 1'b0, 1'b0, 32'h0, 1'b0};
      vecs[3]  = '{1'b0, 9'h000, 1'b0, 1'b0, 9'h000, 32'h0, 3'b000, 1'b0, 32'h0,        1'b0, 1'b0, 9'h000, 32'h0, 3'b000, 1'b0, 32'h00500093, 1'b0, 1'b0, 32'h0, 1'b0};
      vecs[4]  = '{1'b0, 9'h000, 1'b0, 1'b0, 9'h000, 32'h0, 3'b000, 1'b0, 32'h0,        1'b0, 1'b0, 9'h000, 32'h0, 3'b000, 1'b0, 32'h00500093, 1'b0, 1'b0, 32'h0, 1'b0};
      // DM store with 2 wait cycles; requester inputs change mid-BUSY
      vecs[5]  = '{1'b0, 9'h000, 1'b1, 1'b1, 9'h020, 32'hDEADBEEF, 3'b010, 1'b0, 32'h0, 1'b0, 1'b0, 9'h000, 32'h0, 3'b000, 1'b0, 32'h00500093, 1'b0, 1'b0, 32'h0, 1'b1};
      vecs[6]  = '{1'b0, 9'h000, 1'b1, 1'b1, 9'h020, 32'hDEADBEEF, 3'b010, 1'b0, 32'h0, 1'b1, 1'b1, 9'h020, 32'hDEADBEEF, 3'b010, 1'b0, 32'h00500093, 1'b0, 1'b0, 32'h0, 1'b1};
      vecs[7]  = '{1'b0, 9'h000, 1'b1, 1'b1, 9'h1FF, 32'h11111111, 3'b000, 1'b0, 32'h0, 1'b1, 1'b1, 9'h020, 32'hDEADBEEF, 3'b010, 1'b0, 32'h00500093, 1'b0, 1'b0, 32'h0, 1'b1};
      vecs[8]  = '{1'b0, 9'h000, 1'b1, 1'b1, 9'h1FF, 32'h11111111, 3'b000, 1'b1, 32'h12345678, 1'b1, 1'b1, 9'h020, 32'hDEADBEEF, 3'b010, 1'b0, 32'h00500093, 1'b0, 1'b0, 32'h0, 1'b1};
      vecs[9]  = '{1'b0, 9'h000, 1'b1, 1'b1, 9'h1FF, 32'h11111111, 3'b000, 1'b0, 32'h0, 1'b0, 1'b0, 9'h000, 32'h0, 3'b000, 1'b0, 32'h00500093, 1'b0, 1'b1, 32'h0, 1'b0};
      vecs[10] = '{1'b0, 9'h000, 1'b0, 1'b0, 9'h000, 32'h0, 3'b000, 1'b0, 32'h0,        1'b0, 1'b0, 9'h000, 32'h0, 3'b000, 1'b0, 32'h00500093, 1'b0, 1'b0, 32'h0, 1'b0};
      // spurious mem_ready in IDLE
      vecs[11] = '{1'b0, 9'h000, 1'b0, 1'b0, 9'h000, 32'h0, 3'b000, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 9'h000, 32'h0, 3'b000, 1'b0, 32'h00500093, 1'b0, 1'b0, 32'h0, 1'b0};
      vecs[12] = '{1'b0, 9'h000, 1'b0, 1'b0, 9'h000, 32'h0, 3'b000, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 9'h000, 32'h0, 3'b000, 1'b0, 32'h00500093, 1'b0, 1'b0, 32'h0, 1'b0};
      // DM load, byte-unsigned func3 passed through
      vecs[13] = '{1'b0, 9'h000, 1'b1, 1'b0, 9'h044, 32'h0, 3'b100, 1'b1, 32'hCAFEF00D, 1'b0, 1'b0, 9'h000, 32'h0, 3'b000, 1'b0, 32'h00500093, 1'b0, 1'b0, 32'h0, 1'b1};
      vecs[14] = '{1'b0, 9'h000, 1'b1, 1'b0, 9'h044, 32'h0, 3'b100, 1'b1, 32'hCAFEF00D, 1'b1, 1'b0, 9'h044, 32'h0, 3'b100, 1'b0, 32'h00500093, 1'b0, 1'b0, 32'h0, 1'b1};
      vecs[15] = '{1'b0, 9'h000, 1'b1, 1'b0, 9'h044, 32'h0, 3'b100, 1'b0, 32'h0,        1'b0, 1'b0, 9'h000, 32'h0, 3'b000, 1'b0, 32'h00500093, 1'b0, 1'b1, 32'hCAFEF00D, 1'b0};
      vecs[16] = '{1'b0, 9'h000, 1'b0, 1'b0, 9'h000, 32'h0, 3'b000, 1'b0, 32'h0,        1'b0, 1'b0, 9'h000, 32'h0, 3'b000, 1'b0, 32'h00500093, 1'b0, 1'b0, 32'hCAFEF00D, 1'b0};

      exp_order = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

      // reset state
      reset = 1'b0;
      idle_inputs();
      if_req = 1'b1;
      dm_req = 1'b1;
      #3;
      check("rst.mem_req",  {31'b0, mem_req},  32'h0);
      check("rst.if_done",  {31'b0, if_done},  32'h0);
      check("rst.dm_done",  {31'b0, dm_done},  32'h0);
      check("rst.if_stall", {31'b0, if_stall}, 32'h0);
      check("rst.dm_stall", {31'b0, dm_stall}, 32'h0);
      check("rst.if_rdata", if_rdata, 32'h0);
      check("rst.dm_rdata", dm_rdata, 32'h0);
      idle_inputs();
      @(posedge clk);
      @(posedge clk);
      #3 reset = 1'b1;
      tick();
      tick();

      // directed vector table
      for (int v = 0; v < NVEC; v++) begin
         tick();
         if_req    = vecs[v].if_req;
         if_addr   = vecs[v].if_addr;
         dm_req    = vecs[v].dm_req;
         dm_we     = vecs[v].dm_we;
         dm_addr   = vecs[v].dm_addr;
         dm_wdata  = vecs[v].dm_wdata;
         dm_func3  = vecs[v].dm_func3;
         mem_ready = vecs[v].mem_ready;
         mem_rdata = vecs[v].mem_rdata;
         #1;
         check($sformatf("v%0d.mem_req", v),  {31'b0, mem_req},  {31'b0, vecs[v].e_mem_req});
         if (vecs[v].e_mem_req) begin
            check($sformatf("v%0d.mem_we", v),    {31'b0, mem_we},    {31'b0, vecs[v].e_mem_we});
            check($sformatf("v%0d.mem_addr", v),  {23'b0, mem_addr},  {23'b0, vecs[v].e_mem_addr});
            check($sformatf("v%0d.mem_wdata", v), mem_wdata,          vecs[v].e_mem_wdata);
            check($sformatf("v%0d.mem_func3", v), {29'b0, mem_func3}, {29'b0, vecs[v].e_mem_func3});
         end
         check($sformatf("v%0d.if_done", v),  {31'b0, if_done},  {31'b0, vecs[v].e_if_done});
         check($sformatf("v%0d.if_rdata", v), if_rdata,           vecs[v].e_if_rdata);
         check($sformatf("v%0d.if_stall", v), {31'b0, if_stall}, {31'b0, vecs[v].e_if_stall});
         check($sformatf("v%0d.dm_done", v),  {31'b0, dm_done},  {31'b0, vecs[v].e_dm_done});
         check($sformatf("v%0d.dm_rdata", v), dm_rdata,           vecs[v].e_dm_rdata);
         check($sformatf("v%0d.dm_stall", v), {31'b0, dm_stall}, {31'b0, vecs[v].e_dm_stall});
      end

      // tie: both request continuously, MAX_WAIT=4 -> DM x4, IF, DM x4, IF
      tick();
      if_req    = 1'b1;
      if_addr   = 9'h100;
      dm_req    = 1'b1;
      dm_we     = 1'b0;
      dm_addr   = 9'h080;
      dm_func3  = 3'b010;
      mem_ready = 1'b1;
      mem_rdata = 32'h0000A5A5;
      for (int c = 0; c < 60 && order_q.size() < 10; c++) begin
         tick();
         check("tie.done_excl", {31'b0, if_done & dm_done}, 32'h0);
         if (if_done) order_q.push_back(0);
         if (dm_done) order_q.push_back(1);
      end
      check("tie.count", order_q.size(), 32'd10);
      for (int i = 0; i < 10 && i < order_q.size(); i++) begin
         check($sformatf("tie.grant%0d", i), order_q[i], exp_order[i]);
      end
      idle_inputs();
      mem_ready = 1'b1;
      for (int c = 0; c < 4; c++) tick();
      mem_ready = 1'b0;

      // reset asserted while a fetch is in BUSY
      tick();
      if_req  = 1'b1;
      if_addr = 9'h030;
      tick();
      #1;
      check("rbusy.mem_req", {31'b0, mem_req}, 32'h1);
      check("rbusy.if_stall", {31'b0, if_stall}, 32'h1);
      #2;
      reset  = 1'b0;
      dm_req = 1'b1;
      #1;
      check("rasync.mem_req",  {31'b0, mem_req},  32'h0);
      check("rasync.if_done",  {31'b0, if_done},  32'h0);
      check("rasync.dm_done",  {31'b0, dm_done},  32'h0);
      check("rasync.if_stall", {31'b0, if_stall}, 32'h0);
      check("rasync.dm_stall", {31'b0, dm_stall}, 32'h0);
      idle_inputs();
      @(posedge clk);
      #3 reset = 1'b1;
      tick();
      tick();
      check("rpost.mem_req",  {31'b0, mem_req}, 32'h0);
      check("rpost.if_rdata", if_rdata, 32'h0);
      check("rpost.dm_rdata", dm_rdata, 32'h0);

      // fresh fetch after reset: done two cycles after request
      tick();
      if_req    = 1'b1;
      if_addr   = 9'h034;
      mem_ready = 1'b1;
      mem_rdata = 32'h0BADC0DE;
      lat = -1;
      for (int c = 1; c <= 8 && lat < 0; c++) begin
         tick();
         #1;
         if (if_done) lat = c;
      end
      check("rnew.latency", lat, 32'd2);
      check("rnew.if_rdata", if_rdata, 32'h0BADC0DE);
      check("rnew.if_stall", {31'b0, if_stall}, 32'h0);
      idle_inputs();
      tick();
      tick();
      check("rnew.idle_mem_req", {31'b0, mem_req}, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
